fetch_sequencer: RTL

Instruction-fetch controller sitting between the program counter and the instruction ROM. Owns the fetch PC, issues one ROM read per cycle when buffer space allows, buffers returned instructions in a small FIFO, and presents them to decode over a valid/ready handshake. It accepts a branch redirect from execute, which flushes the buffer and discards any in-flight read.

---
 rtl/fetch_sequencer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the fetch PC, issues ROM reads and buffers the returned words
// for decode. Define FETCH_PERF_EN to add the perf_fetched/perf_stall counters.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        rom_en,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StFull} state_e;

  state_e            state_q, state_d;
  logic [31:0]       fpc_q, fpc_d;
  logic [31:0]       ret_pc_q;
  logic              inflight_q, kill_q;
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [31:0]       pc_mem  [DEPTH];
  logic [31:0]       ins_mem [DEPTH];
  logic              pop, push, issue, has_space;
  logic [CntW:0]     occ_after_pop, occ_next;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    instr_valid   = (count_q != '0);
    pop           = instr_valid & instr_ready;
    push          = inflight_q & ~kill_q;
    // Space is counted against buffered plus in-flight entries so a push never overflows.
    occ_after_pop = {1'b0, count_q} + (CntW + 1)'(inflight_q) - (CntW + 1)'(pop);
    has_space     = occ_after_pop < (CntW + 1)'(DEPTH);
    issue         = (state_q == StRun) & en & ~redirect & has_space;
    rom_en        = issue;
    rom_addr      = fpc_q;
    instr         = ins_mem[rd_ptr_q];
    instr_pc      = pc_mem[rd_ptr_q];
  end

  always_comb begin
    fpc_d    = fpc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    state_d  = state_q;
    if (redirect) begin
      fpc_d    = redirect_pc;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (issue) fpc_d = fpc_q + 32'd4;
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
    occ_next = {1'b0, count_d} + (CntW + 1)'(issue);
    if (!en) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:        state_d = StRun;
        StRun, StFull: state_d = (occ_next >= (CntW + 1)'(DEPTH)) ? StFull : StRun;
        default:       state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      fpc_q      <= RESET_PC;
      ret_pc_q   <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem[i]  <= '0;
        ins_mem[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fpc_q      <= fpc_d;
      inflight_q <= issue;
      kill_q     <= redirect & inflight_q;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      if (issue) ret_pc_q <= fpc_q;
      // A redirect empties the buffer, so the word returning this cycle is dropped too.
      if (push && !redirect) begin
        pc_mem[wr_ptr_q]  <= ret_pc_q;
        ins_mem[wr_ptr_q] <= rom_data;
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (pop) perf_fetched <= perf_fetched + 32'd1;
      if (instr_valid && !instr_ready) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
